cla_4bit_adder: RTL and testbench



---
 rtl/cla_4bit_adder_pkg.sv | 13 +
 rtl/cla_4bit_adder_if.sv | 31 +++
 rtl/cla_4bit_core.sv | 55 +++++
 rtl/cla_4bit_adder.sv | 63 ++++++
 tb/tb_cla_4bit_adder.sv | 117 +++++++++++
 5 files changed

// File: rtl/cla_4bit_adder_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared width constant and sum type for the 4-bit carry-lookahead adder.
//   CLA_W     : operand / sum width (fixed at 4)
//   cla_sum_t : CLA_W-bit vector type for operands and sum
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int unsigned CLA_W = 4;

    typedef logic [CLA_W-1:0] cla_sum_t;

endpackage : cla_pkg

// File: rtl/cla_4bit_adder_if.sv
// -----------------------------------------------------------------------------
// cla_4bit_adder_if
// Operand/result bundle for cla_4bit_adder.
//   master : drives in_valid, a, b, cin; observes sum, cout, grp_p, grp_g,
//            out_valid
//   slave  : the adder side, the reverse directions
// -----------------------------------------------------------------------------
interface cla_4bit_adder_if;
    import cla_pkg::*;

    logic     in_valid;
    cla_sum_t a;
    cla_sum_t b;
    logic     cin;
    cla_sum_t sum;
    logic     cout;
    logic     grp_p;
    logic     grp_g;
    logic     out_valid;

    modport master (
        output in_valid, a, b, cin,
        input  sum, cout, grp_p, grp_g, out_valid
    );

    modport slave (
        input  in_valid, a, b, cin,
        output sum, cout, grp_p, grp_g, out_valid
    );

endinterface : cla_4bit_adder_if

// File: rtl/cla_4bit_core.sv
// -----------------------------------------------------------------------------
// cla_4bit_core
// Purely combinational 4-bit carry-lookahead adder.
//   a_i, b_i : operands
//   cin_i    : carry in
//   sum_o    : sum bits
//   cout_o   : carry out (c4)
//   grp_p_o  : group propagate, all bits propagate
//   grp_g_o  : group generate, carry out independent of cin
// -----------------------------------------------------------------------------
module cla_4bit_core
    import cla_pkg::*;
(
    input  cla_sum_t a_i,
    input  cla_sum_t b_i,
    input  logic     cin_i,
    output cla_sum_t sum_o,
    output logic     cout_o,
    output logic     grp_p_o,
    output logic     grp_g_o
);

    cla_sum_t         g;
    cla_sum_t         p;
    logic [CLA_W:0]   c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Every carry is a flat sum of products of g/p and cin, no ripple chain.
    assign c[0] = cin_i;
    assign c[1] = g[0]
                | (p[0] & c[0]);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & c[0]);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum_o   = p ^ c[CLA_W-1:0];
    assign cout_o  = c[4];
    assign grp_p_o = &p;
    assign grp_g_o = g[3]
                   | (p[3] & g[2])
                   | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]);

endmodule : cla_4bit_core

// File: rtl/cla_4bit_adder.sv
// -----------------------------------------------------------------------------
// cla_4bit_adder
// Registered 4-bit carry-lookahead adder, one cycle latency, one op per cycle.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears all outputs
//   bus   : slave side of cla_4bit_adder_if
//           in_valid, a, b, cin             -> operands
//           sum, cout, grp_p, grp_g          <- registered results
//           out_valid                        <- registered in_valid
// Result registers load every cycle; in_valid only qualifies out_valid.
// -----------------------------------------------------------------------------
module cla_4bit_adder
    import cla_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    cla_4bit_adder_if.slave   bus
);

    cla_sum_t sum_d;
    logic     cout_d;
    logic     grp_p_d;
    logic     grp_g_d;

    cla_sum_t sum_q;
    logic     cout_q;
    logic     grp_p_q;
    logic     grp_g_q;
    logic     out_valid_q;

    cla_4bit_core u_core (
        .a_i     (bus.a),
        .b_i     (bus.b),
        .cin_i   (bus.cin),
        .sum_o   (sum_d),
        .cout_o  (cout_d),
        .grp_p_o (grp_p_d),
        .grp_g_o (grp_g_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            grp_p_q     <= 1'b0;
            grp_g_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            grp_p_q     <= grp_p_d;
            grp_g_q     <= grp_g_d;
            out_valid_q <= bus.in_valid;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.grp_p     = grp_p_q;
    assign bus.grp_g     = grp_g_q;
    assign bus.out_valid = out_valid_q;

endmodule : cla_4bit_adder

// File: tb/tb_cla_4bit_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_4bit_adder
// Directed and exhaustive checks of cla_4bit_adder. Inputs change on the
// falling edge; outputs are sampled on the following falling edge.
// -----------------------------------------------------------------------------
module tb_cla_4bit_adder;

    logic clk;
    logic rst_n;
    int unsigned n_checks;
    int unsigned n_fail;

    cla_4bit_adder_if bus ();

    cla_4bit_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got,
                            input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic c);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
    endtask

    task automatic check_all(input string tag, input logic [3:0] s,
                             input logic co, input logic gp, input logic gg,
                             input logic ov);
        check_eq({tag, ".sum"},   {4'h0, bus.sum},   {4'h0, s});
        check_eq({tag, ".cout"},  {7'h0, bus.cout},  {7'h0, co});
        check_eq({tag, ".grp_p"}, {7'h0, bus.grp_p}, {7'h0, gp});
        check_eq({tag, ".grp_g"}, {7'h0, bus.grp_g}, {7'h0, gg});
        check_eq({tag, ".valid"}, {7'h0, bus.out_valid}, {7'h0, ov});
    endtask

    // Apply one operand set for one cycle, then check the registered result.
    task automatic vec(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [3:0] s, input logic co,
                       input logic gp, input logic gg);
        drive(1'b1, a, b, c);
        @(negedge clk);
        check_all(tag, s, co, gp, gg, 1'b1);
    endtask

    initial begin
        logic [4:0] full;
        logic [3:0] ea;
        logic [3:0] eb;
        logic       ec;

        n_checks = 0;
        n_fail   = 0;

        // Reset held for two edges with nonzero operands.
        rst_n = 1'b0;
        drive(1'b1, 4'hF, 4'hF, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check_all("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        vec("zero",     4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        vec("carryin",  4'b0001, 4'b0110, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
        vec("generate", 4'b1010, 4'b1111, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b1);
        vec("prop_c1",  4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
        vec("prop_c0",  4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0);

        // in_valid low: result registers still load, out_valid stays low.
        drive(1'b0, 4'b0011, 4'b0101, 1'b0);
        @(negedge clk);
        check_all("novalid", 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);

        // All 512 combinations on consecutive cycles.
        for (int i = 0; i < 512; i++) begin
            ea = i[3:0];
            eb = i[7:4];
            ec = i[8];
            drive(1'b1, ea, eb, ec);
            @(negedge clk);
            full = {1'b0, ea} + {1'b0, eb} + {4'h0, ec};
            check_eq("exh.sum",   {4'h0, bus.sum},  {4'h0, full[3:0]});
            check_eq("exh.cout",  {7'h0, bus.cout}, {7'h0, full[4]});
            check_eq("exh.grp_p", {7'h0, bus.grp_p}, {7'h0, &(ea ^ eb)});
            check_eq("exh.grp_g", {7'h0, bus.grp_g},
                     {7'h0, (({1'b0, ea} + {1'b0, eb}) > 5'd15)});
            check_eq("exh.valid", {7'h0, bus.out_valid}, 8'h01);
        end

        // Mid-stream reset discards the operation in flight.
        rst_n = 1'b0;
        drive(1'b1, 4'b0011, 4'b0100, 1'b0);
        @(negedge clk);
        check_all("midreset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        // 9 + 8 + 1 = 18 -> cout=1 sum=0010; p=0001, g=1000.
        vec("postreset", 4'b1001, 4'b1000, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cla_4bit_adder
